// File: rtl/fir_mac_seq.sv
// Sequencer for one shared MAC running an N-tap direct-form FIR: delay line, coefficient ROM address, MAC control, round/format.
// Define FIR_SAT_EN to saturate the output sample; otherwise the rounded sum wraps to Win bits.
//
// state | meaning
// IDLE  | waiting for a sample; ready high
// LOAD  | new sample stored; MAC accumulator cleared this cycle
// RUN   | N cycles stepping tap k; ROM address and MAC operand issued
// DRAIN | last registered operand/enable reaches the MAC
// OUT   | accumulator final; round, format, advance write pointer
module fir_mac_seq #(
    parameter int N     = 16,
    parameter int Win   = 16,
    parameter int Wc    = 18,
    parameter int AW    = $clog2(N),
    parameter int SHIFT = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    input  logic [Win-1:0]    din,
    output logic              ready,
    output logic [AW-1:0]     coef_addr,
    input  logic [Wc-1:0]     coef,
    output logic [Win-1:0]    mac_din,
    output logic              mac_ce,
    output logic              mac_rst,
    input  logic [Win+Wc-1:0] mac_dout,
    output logic [Win-1:0]    dout,
    output logic              dout_valid
);

    localparam int WA = Win + Wc;
    localparam int WR = WA + 1;
    localparam logic [AW:0]   N_EXT  = (AW + 1)'(N);
    localparam logic [AW-1:0] K_LAST = AW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  k_q, k_d;
    logic [Win-1:0] delay_q [N];
    logic [Win-1:0] delay_d [N];
    logic           ready_q, ready_d;
    logic           mac_ce_q, mac_ce_d;
    logic [Win-1:0] mac_din_q, mac_din_d;
    logic [Win-1:0] dout_q, dout_d;
    logic           dout_valid_q, dout_valid_d;

    // Newest sample sits at wr_ptr; tap k reads (wr_ptr - k) mod N.
    logic [AW:0]   idx_sum, idx_wrap;
    logic [AW-1:0] tap_idx;

    always_comb begin
        idx_sum  = {1'b0, wr_ptr_q} + N_EXT - {1'b0, k_q};
        idx_wrap = (idx_sum >= N_EXT) ? (idx_sum - N_EXT) : idx_sum;
    end

    assign tap_idx = idx_wrap[AW-1:0];

    // One extra bit of headroom so the rounding add can never wrap.
    logic signed [WR-1:0] acc_ext;
    logic signed [WR-1:0] r_val;
    logic [Win-1:0]       fmt_val;

    assign acc_ext = $signed({mac_dout[WA-1], mac_dout});

    generate
        if (SHIFT == 0) begin : g_no_round
            assign r_val = acc_ext;
        end else begin : g_round
            localparam logic signed [WR-1:0] HALF = WR'(1) << (SHIFT - 1);
            assign r_val = (acc_ext + HALF) >>> SHIFT;
        end
    endgenerate

`ifdef FIR_SAT_EN
    always_comb begin
        if (r_val[WR-1:Win-1] == {(WR - Win + 1){r_val[WR-1]}}) begin
            fmt_val = r_val[Win-1:0];
        end else if (r_val[WR-1]) begin
            fmt_val = {1'b1, {(Win - 1){1'b0}}};
        end else begin
            fmt_val = {1'b0, {(Win - 1){1'b1}}};
        end
    end
`else
    assign fmt_val = r_val[Win-1:0];
`endif

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        k_d          = k_q;
        delay_d      = delay_q;
        ready_d      = ready_q;
        mac_ce_d     = 1'b0;
        mac_din_d    = mac_din_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (din_valid) begin
                    delay_d[wr_ptr_q] = din;
                    ready_d           = 1'b0;
                    state_d           = S_LOAD;
                end
            end
            S_LOAD: begin
                k_d     = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                mac_din_d = delay_q[tap_idx];
                mac_ce_d  = 1'b1;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = S_OUT;
            end
            S_OUT: begin
                dout_d       = fmt_val;
                dout_valid_d = 1'b1;
                wr_ptr_d     = (wr_ptr_q == K_LAST) ? '0 : wr_ptr_q + 1'b1;
                ready_d      = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            k_q          <= '0;
            for (int i = 0; i < N; i++) begin
                delay_q[i] <= '0;
            end
            ready_q      <= 1'b1;
            mac_ce_q     <= 1'b0;
            mac_din_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            k_q          <= k_d;
            delay_q      <= delay_d;
            ready_q      <= ready_d;
            mac_ce_q     <= mac_ce_d;
            mac_din_q    <= mac_din_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign ready      = ready_q;
    assign coef_addr  = k_q;
    assign mac_din    = mac_din_q;
    assign mac_ce     = mac_ce_q;
    assign mac_rst    = rst | (state_q == S_LOAD);
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

    // ROM data goes straight to the MAC; the top pointer bit is always zero after wrap.
    logic unused_bits;
    assign unused_bits = ^{coef, idx_wrap[AW], r_val};

endmodule

// File: doc/fir_mac_seq.md
Name: fir_mac_seq

Overview:
Sequencer for a single shared multiply-accumulate unit implementing an N-tap direct-form FIR. It holds the sample delay line, drives the coefficient ROM address, and issues clear and enable to the MAC. It rounds and saturates the accumulator into an output sample. It sits between the sample stream and the MAC/ROM pair in the filter datapath.

Parameters:
N, 16, number of taps (>=2)
Win, 16, input/output sample width (signed)
Wc, 18, coefficient width (signed)
AW, $clog2(N), tap index width
SHIFT, 17, fractional bits removed from the accumulator on output (0 = no shift, no rounding)

Ports:
clk  in  1  clock
rst  in  1  reset
din_valid  in  1  input sample strobe
din  in  Win  input sample, signed
ready  out  1  block can accept a sample this cycle
coef_addr  out  AW  coefficient ROM address (synchronous ROM, 1-cycle read latency)
coef  in  Wc  ROM data; routed externally to the MAC coef input, not used internally
mac_din  out  Win  sample operand to the MAC
mac_ce  out  1  MAC accumulate enable
mac_rst  out  1  MAC accumulator clear
mac_dout  in  Win+Wc  MAC accumulator value
dout  out  Win  filtered sample, signed
dout_valid  out  1  one-cycle strobe, dout valid

Behaviour:
- Reset: rst is synchronous and active-high, on clock clk. On reset: state=IDLE; wr_ptr=0; delay line cleared to 0; ready=1; mac_ce=0; mac_din=0; coef_addr=0; dout=0; dout_valid=0.
- mac_rst = rst OR (state==LOAD). This output is combinational.
- FSM states: IDLE, LOAD, RUN, DRAIN, OUT.
- IDLE: ready=1. If din_valid, write din to delay[wr_ptr] and go to LOAD. Otherwise stay.
- LOAD: one cycle, ready=0, mac_rst=1, so the accumulator is cleared at the end of this cycle. Initialise tap counter k=0. Go to RUN.
- RUN: N cycles, k=0..N-1.
  - coef_addr=k.
  - Sample index = (wr_ptr - k) mod N, newest sample first.
  - mac_din is registered from that sample, so it aligns with the ROM data one cycle later.
  - mac_ce is registered high, so it is 1 during cycles RUN+1 .. RUN+N.
  - After k==N-1, go to DRAIN.
- DRAIN: one cycle. The last registered mac_ce and mac_din are active. Go to OUT.
- OUT: one cycle. mac_ce=0 and mac_dout holds the final sum.
  - Compute r = (mac_dout + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift, round half toward +inf. The add is skipped when SHIFT=0.
  - Register dout = fmt(r) and set dout_valid=1 for the next cycle.
  - Advance wr_ptr = (wr_ptr+1) mod N; the pointer wraps N-1 -> 0.
  - Go to IDLE.
- Latency: accept at cycle t gives dout_valid=1 at t+N+4. ready=0 from t+1 through t+N+3, so the maximum rate is 1 sample per N+4 cycles.
- A new sample may be accepted in the same cycle that dout_valid is high.
- din_valid while ready=0 is ignored; the sample is dropped and no state changes.
- Accumulator growth is sized by Win+Wc. Coefficient sets must satisfy sum|coef|*2^(Win-1) < 2^(Win+Wc-1); the block does not detect accumulator overflow.
- rst in any state (including mid-RUN) aborts the computation: no dout_valid, IDLE next cycle, delay line cleared.
- The rounding intermediate is Win+Wc+1 bits wide, so the rounding add never wraps.

Optional Feature:
FIR_SAT_EN
- Defined: fmt(r) saturates to the range [-2^(Win-1), 2^(Win-1)-1].
- Undefined: fmt(r) takes the low Win bits of r (two's-complement wrap). There is no saturation logic.

Test Plan:
- Impulse response: N=4, SHIFT=0, coefs {1,2,3,4}. Input samples 1,0,0,0,0 -> dout 1,2,3,4,0.
- Timing: accept at cycle t -> dout_valid high only at t+8 (N=4). ready low t+1..t+7. A back-to-back din_valid at t+8 is accepted.
- Rounding: N=4, SHIFT=2, coefs {1,0,0,0}.
  - Input 6 -> 2.
  - Input -6 -> -1.
  - Input 5 -> 1.
  - Input -7 -> -2.
- Saturation: N=4, SHIFT=0, coefs all 1. Four samples of 32767 -> last dout 32767 with FIR_SAT_EN, -4 without. Four samples of -32768 -> -32768 with FIR_SAT_EN, 0 without.
- Busy drop: din_valid held high continuously with incrementing din -> only samples presented while ready=1 appear in the outputs. Verify against a reference model.
- Mid-run reset: rst for one cycle during RUN -> no dout_valid, ready=1 next cycle. A following impulse then yields a clean 1,2,3,4 response, with no residue from the old samples.
